// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and the window-stage FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_pkg;

  localparam int PIX_W = 8;          // bits per pixel
  localparam int IMG_W = 28;         // pixels per row
  localparam int IMG_H = 28;         // rows per image
  localparam int WIN_W = 9 * PIX_W;  // packed 3x3 window width

  typedef enum logic [1:0] {
    FILL = 2'd0,   // collecting the first three rows of an image
    SCAN = 2'd1,   // emitting one window per cycle across the row buffer
    WAIT = 2'd2    // pass finished early, idle until the next row arrives
  } win_state_t;

endpackage

// File: rtl/win_mux3.sv
// Selects the 3-pixel slice starting at column col_i from one image row.
// Latency: combinational.
// Backpressure: none.
// Ports: row_i (IMG_W*PIX_W, pixel 0 in the MSBs), col_i (start column),
//        slice_o (3*PIX_W, leftmost pixel in the MSBs).
module win_mux3 #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 28
) (
  input  logic [IMG_W*PIX_W-1:0] row_i,
  input  logic [4:0]             col_i,
  output logic [3*PIX_W-1:0]     slice_o
);

  localparam int ROW_W = IMG_W * PIX_W;

  // One constant-bounded slice per legal start column; out-of-range columns
  // yield zero rather than reading past the row.
  always_comb begin
    slice_o = '0;
    for (int i = 0; i < IMG_W - 2; i++) begin
      if (col_i == 5'(i)) begin
        slice_o = row_i[ROW_W-1-PIX_W*i -: 3*PIX_W];
      end
    end
  end

endmodule

// File: rtl/conv_window3x3.sv
// 3x3 sliding-window generator over the three most recent image rows.
// Latency: first window of a pass is valid the cycle after its newest row is accepted.
// Backpressure: none; a row strobe mid-scan is dropped (flagged when CONV_WIN_OVERRUN_CHK_EN is defined).
// Ports: clk/rst (sync active-high), in_row/row_valid (row input),
//        win_data/win_valid/win_col/win_row (window output), frame_done (last window pulse),
//        err_overrun (sticky dropped-strobe flag; tied 0 unless CONV_WIN_OVERRUN_CHK_EN).
module conv_window3x3 #(
  parameter int PIX_W = cnn_pkg::PIX_W,
  parameter int IMG_W = cnn_pkg::IMG_W,
  parameter int IMG_H = cnn_pkg::IMG_H
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IMG_W*PIX_W-1:0] in_row,
  input  logic                   row_valid,
  output logic [9*PIX_W-1:0]     win_data,
  output logic                   win_valid,
  output logic [4:0]             win_col,
  output logic [4:0]             win_row,
  output logic                   frame_done,
  output logic                   err_overrun
);

  import cnn_pkg::*;

  localparam int ROW_W = IMG_W * PIX_W;
  localparam int OUT_W = IMG_W - 2;
  localparam logic [4:0] LAST_COL  = 5'(OUT_W - 1);
  localparam logic [4:0] FULL_ROWS = 5'(IMG_H);

  win_state_t       state_q, state_d;
  logic [ROW_W-1:0] rb0_q, rb1_q, rb2_q;
  logic [ROW_W-1:0] rb0_d, rb1_d, rb2_d;
  logic [4:0]       rows_in_q, rows_in_d;
  logic [4:0]       col_q, col_d;
  logic [4:0]       row_q, row_d;
  logic [9*PIX_W-1:0] win_data_q;
  logic             win_valid_q, frame_done_q;
  logic             accept;
  logic [3*PIX_W-1:0] s0, s1, s2;

  always_comb begin
    state_d   = state_q;
    rows_in_d = rows_in_q;
    col_d     = col_q;
    row_d     = row_q;
    accept    = 1'b0;
    case (state_q)
      FILL: begin
        if (row_valid) begin
          accept    = 1'b1;
          rows_in_d = rows_in_q + 5'd1;
          if (rows_in_q == 5'd2) begin
            state_d = SCAN;
            col_d   = '0;
          end
        end
      end
      SCAN: begin
        if (col_q == LAST_COL) begin
          if (rows_in_q == FULL_ROWS) begin
            // Image complete: a coincident strobe is row 0 of the next image.
            state_d   = FILL;
            row_d     = '0;
            rows_in_d = '0;
            if (row_valid) begin
              accept    = 1'b1;
              rows_in_d = 5'd1;
            end
          end else begin
            row_d = row_q + 5'd1;
            if (row_valid) begin
              // Back-to-back: start the next pass with no idle cycle.
              accept    = 1'b1;
              rows_in_d = rows_in_q + 5'd1;
              col_d     = '0;
            end else begin
              state_d = WAIT;
            end
          end
        end else begin
          col_d = col_q + 5'd1;
        end
      end
      WAIT: begin
        if (row_valid) begin
          accept    = 1'b1;
          rows_in_d = rows_in_q + 5'd1;
          state_d   = SCAN;
          col_d     = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign rb0_d = accept ? rb1_q  : rb0_q;
  assign rb1_d = accept ? rb2_q  : rb1_q;
  assign rb2_d = accept ? in_row : rb2_q;

  // Slices are taken from next-state buffer/column so the window can be
  // registered in the same edge that accepts its newest row.
  win_mux3 #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_mux0 (.row_i(rb0_d), .col_i(col_d), .slice_o(s0));
  win_mux3 #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_mux1 (.row_i(rb1_d), .col_i(col_d), .slice_o(s1));
  win_mux3 #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_mux2 (.row_i(rb2_d), .col_i(col_d), .slice_o(s2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      rb0_q        <= '0;
      rb1_q        <= '0;
      rb2_q        <= '0;
      rows_in_q    <= '0;
      col_q        <= '0;
      row_q        <= '0;
      win_data_q   <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rb0_q        <= rb0_d;
      rb1_q        <= rb1_d;
      rb2_q        <= rb2_d;
      rows_in_q    <= rows_in_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= (state_d == SCAN);
      frame_done_q <= (state_d == SCAN) && (col_d == LAST_COL) && (rows_in_d == FULL_ROWS);
      if (state_d == SCAN) begin
        win_data_q <= {s0, s1, s2};
      end
    end
  end

`ifdef CONV_WIN_OVERRUN_CHK_EN
  logic overrun;
  logic err_q;

  assign overrun = (state_q == SCAN) && (col_q != LAST_COL) && row_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (overrun) begin
      err_q <= 1'b1;
    end
  end

  assign err_overrun = err_q;
`else
  assign err_overrun = 1'b0;
`endif

  assign win_data   = win_data_q;
  assign win_valid  = win_valid_q;
  assign win_col    = col_q;
  assign win_row    = row_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window3x3.sv
// Randomized scoreboard bench for conv_window3x3: the stimulus pushes the
// windows each accepted row implies; a negedge monitor pops and compares.
module tb_conv_window3x3;

  localparam int PIX_W = 8;
  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int OUT_W = IMG_W - 2;
  localparam int ROW_W = IMG_W * PIX_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             row_valid = 1'b0;
  logic [ROW_W-1:0] in_row = '0;
  logic [71:0]      win_data;
  logic             win_valid;
  logic [4:0]       win_col;
  logic [4:0]       win_row;
  logic             frame_done;
  logic             err_overrun;

  always #5 clk = ~clk;

  conv_window3x3 dut (
    .clk        (clk),
    .rst        (rst),
    .in_row     (in_row),
    .row_valid  (row_valid),
    .win_data   (win_data),
    .win_valid  (win_valid),
    .win_col    (win_col),
    .win_row    (win_row),
    .frame_done (frame_done),
    .err_overrun(err_overrun)
  );

  typedef struct {
    logic [71:0] d;
    int          col;
    int          row;
    bit          fd;
  } exp_t;

  exp_t             expq[$];
  logic [ROW_W-1:0] img[$];
  exp_t             e;
  int vectors = 0;
  int miscompares = 0;
  int run_len = 0, gap_len = 0, last_run = 0, last_gap = 0;
  bit exp_err;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [ROW_W-1:0] rand_row();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [ROW_W-1:0] pat_row(input int r);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int c = 0; c < IMG_W; c++) v[ROW_W-1-8*c -: 8] = 8'(16 * r + c);
    return v;
  endfunction

  // Window (r,k) = pixel col+k of the r-th oldest of three rows.
  function automatic logic [71:0] window(input logic [ROW_W-1:0] a, input logic [ROW_W-1:0] b,
                                         input logic [ROW_W-1:0] c, input int col);
    logic [ROW_W-1:0] rows [3];
    logic [71:0] w;
    rows[0] = a; rows[1] = b; rows[2] = c;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        w[71-8*(3*r+k) -: 8] = rows[r][ROW_W-1-8*(col+k) -: 8];
    return w;
  endfunction

  // Reference: every accepted row from the third onward yields one full pass.
  task automatic model_row(input logic [ROW_W-1:0] d);
    int n;
    img.push_back(d);
    n = img.size();
    if (n >= 3) begin
      for (int col = 0; col < OUT_W; col++)
        expq.push_back('{window(img[n-3], img[n-2], img[n-1], col), col, n - 3,
                         (n == IMG_H) && (col == OUT_W - 1)});
    end
    if (n == IMG_H) img.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; strobe is sampled at the following posedge.
  task automatic strobe(input logic [ROW_W-1:0] d, input bit legit);
    if (legit) model_row(d);
    in_row    = d;
    row_valid = 1'b1;
    @(negedge clk);
    row_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 96'(win_valid), 96'd0);
    chk({tag, "_frame_done"}, 96'(frame_done), 96'd0);
    chk({tag, "_err"}, 96'(err_overrun), 96'd0);
    chk({tag, "_col"}, 96'(win_col), 96'd0);
    chk({tag, "_row"}, 96'(win_row), 96'd0);
    chk({tag, "_data"}, 96'(win_data), 96'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (win_valid) begin
        if (gap_len > 0) last_gap = gap_len;
        gap_len = 0;
        run_len++;
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_window actual=valid col=%0d row=%0d required=no window at %0t",
                   win_col, win_row, $time);
        end else begin
          e = expq.pop_front();
          chk("window", {13'd0, win_row, win_col, frame_done, win_data},
              {13'd0, 5'(e.row), 5'(e.col), e.fd, e.d});
        end
      end else begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
        gap_len++;
        chk("frame_done_idle", 96'(frame_done), 96'd0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
`ifdef CONV_WIN_OVERRUN_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst = 1'b1;
    idle(3);
    chk_zero("reset");
    rst = 1'b0;

    // Image 1 at a 26-cycle row period; rows 0..2 use the known pattern.
    for (int r = 0; r < IMG_H; r++) begin
      strobe((r < 3) ? pat_row(r) : rand_row(), 1'b1);
      if (r == 2) begin
        chk("first_window", 96'(win_data), 96'h000102101112202122);
        chk("first_col", 96'(win_col), 96'd0);
      end
      idle(25);
      if (r == 2) begin
        chk("last_window", 96'(win_data), 96'h191A1B292A2B393A3B);
        chk("last_col", 96'(win_col), 96'd25);
      end
    end
    // Coincident with frame_done: row 0 of image 2.
    strobe(rand_row(), 1'b1);
    idle(1);
    chk("continuous_run", 96'(last_run), 96'd676);

    // Image 2: rows 1,2 in FILL, then an extra strobe at col 10.
    strobe(rand_row(), 1'b1);
    idle(4);
    strobe(rand_row(), 1'b1);
    idle(10);
    chk("err_before", 96'(err_overrun), 96'd0);
    strobe(rand_row(), 1'b0);
    chk("err_overrun", 96'(err_overrun), 96'(exp_err));
    idle(14);
    strobe(rand_row(), 1'b1);               // row 3
    for (int r = 4; r <= 6; r++) begin      // 40-cycle period
      idle(39);
      strobe(rand_row(), 1'b1);
    end
    idle(1);
    chk("wait_gap", 96'(last_gap), 96'd14);
    idle(24);
    strobe(rand_row(), 1'b1);               // row 7 -> pass 5
    idle(12);
    rst = 1'b1;
    @(posedge clk);
    expq.delete();
    img.delete();
    @(negedge clk);
    chk_zero("midscan_reset");
    rst = 1'b0;

    // Image 3 after reset: random FILL spacing, random 26..40 row period.
    for (int r = 0; r < IMG_H; r++) begin
      strobe(rand_row(), 1'b1);
      if (r < 2) idle($urandom_range(0, 4));
      else if (r < IMG_H - 1) idle($urandom_range(25, 39));
    end
    idle(40);
    chk("queue_drained", 96'(expq.size()), 96'd0);
    chk("err_after_reset", 96'(err_overrun), 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_window3x3.md
# conv_window3x3

Downstream neighbour of the row-latch stage in the CNN datapath. Receives one 28-pixel image row (224 bits) per `row_valid` pulse and holds the three most recent rows. Once three rows are held, it scans them left to right, emitting one 3×3 window per cycle for 26 cycles. The convolution MAC stage consumes these windows.

## Interface
Parameters:
- `PIX_W`, 8, bits per pixel
- `IMG_W`, 28, pixels per row
- `IMG_H`, 28, rows per image
- `OUT_W`, derived as `IMG_W-2` (26), windows per row; not overridable

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_row`  in  `IMG_W*PIX_W` (224)  image row; pixel c occupies `in_row[223-8c -: 8]`
- `row_valid`  in  1  single-cycle strobe; `in_row` is valid this cycle
- `win_data`  out  72  3×3 window; element (r,k) occupies `[71-8*(3r+k) -: 8]`; r=0 is the oldest row, k=0 the leftmost column
- `win_valid`  out  1  `win_data` is valid this cycle
- `win_col`  out  5  output column index, 0..25
- `win_row`  out  5  output row index, 0..25
- `frame_done`  out  1  one-cycle pulse, coincident with the final window of an image
- `err_overrun`  out  1  sticky flag: a row strobe was dropped

## Operation
- Three-deep row buffer `rb0..rb2`. On accept: `rb0<=rb1; rb1<=rb2; rb2<=in_row`.
- Row counter `rows_in` (0..28) counts rows accepted in the current image.
- FSM states:
  - FILL: accept every strobe. When an accept makes `rows_in==3`, go to SCAN.
  - SCAN: `win_col` counts 0..25. `win_data` = columns `col..col+2` of `rb0,rb1,rb2`, `win_valid=1`.
  - WAIT: `win_valid=0`. Accept a strobe, then go to SCAN.
- End of a SCAN pass (`col==25`):
  - If `rows_in<28`, go to WAIT. If a strobe is present on this same cycle, accept it and go straight to SCAN (back-to-back).
  - If `rows_in==28`, pulse `frame_done`, clear `rows_in`, and go to FILL. A strobe on this cycle is accepted as row 0 of the next image (`rows_in<=1`).
- `win_row` increments at the end of each pass and clears with `frame_done`.
- A strobe in SCAN with `col!=25` is ignored: the buffer is unchanged and `err_overrun` is set.
- Reset values:
  - `win_valid`, `frame_done`, `err_overrun`, `win_col`, `win_row`, `rows_in`: 0.
  - `win_data`: 0; buffer contents: 0.
  - State: FILL.
- Reset mid-scan aborts the scan immediately. The first window after reset requires three new rows.

## Timing
- Outputs are registered.
- Latency: the first window of a pass is valid in the cycle after the edge that accepted its third/newest row.
- A pass occupies exactly 26 consecutive `win_valid` cycles.
- The minimum row period that sustains continuous output is 26 cycles. This matches the upstream stage's 26-cycle cadence; the strobe coincides with the `col==25` cycle.
- Per image: 26 passes, 676 windows. `frame_done` is high with `win_col=25`, `win_row=25`.
- `win_col` and `win_row` are only meaningful when `win_valid=1`. They hold their last value otherwise.

## Configuration
- Macro `CONV_WIN_OVERRUN_CHK_EN`.
- Defined: the overrun detection above is present. `err_overrun` is sticky and cleared only by `rst`.
- Undefined: the detection logic is omitted and `err_overrun` is tied to 0. Dropped strobes are still ignored.

## Structure
- Shared package `cnn_pkg` holds:
  - `PIX_W`, `IMG_W`, `IMG_H`;
  - the window-width constant `WIN_W=9*PIX_W`;
  - the FSM state enum typedef `win_state_t` (FILL, SCAN, WAIT).
- One sub-module, `win_mux3`. It selects the 3-pixel slice at column `col` from a 224-bit row and is instantiated three times.

## Test plan
- Reset, then rows R0..R2 where pixel c = `8'h10*r + c`, strobes spaced 26 cycles apart:
  - First window, 1 cycle after R2's accept: `{00,01,02,10,11,12,20,21,22}` hex, `win_col=0`.
  - Last window, 25 cycles later: `{19,1A,1B,29,2A,2B,...}`.
- Full 28-row image at a 26-cycle period:
  - `win_valid` stays continuously high for 676 cycles.
  - `frame_done` is a single pulse at `win_row=25`, `win_col=25`.
- Extra strobe at `col==10`:
  - The pass completes with unchanged data.
  - `err_overrun=1` with the macro defined; `err_overrun=0` with it undefined.
- Rows delayed to a 40-cycle period:
  - 14-cycle `win_valid=0` gaps in WAIT.
  - Window contents are unchanged from the 26-cycle case.
- Assert `rst` at `col==12` of pass 5:
  - All outputs are 0 on the next cycle.
  - No window appears until three new rows have been accepted.
- Strobe coincident with `frame_done`: it becomes row 0 of the next image, and the next `win_valid` follows two more accepted rows.
